// File: rtl/disp_pkg.sv
// Shared definitions for the display VRAM read arbiter: FSM encodings,
// requester indices and default arbitration parameters.
package disp_pkg;

  typedef enum logic [2:0] {
    S_ARB_IDLE = 3'b001,
    S_ARB_ADDR = 3'b010,
    S_ARB_DATA = 3'b100
  } arb_state_e;

  localparam logic REQ_DISP = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  localparam int unsigned MAXWAIT_DEF = 4;
  localparam int unsigned CW_DEF      = 3;

endpackage

// File: rtl/disp_vramarb_sel.sv
// Winner selection for the VRAM arbiter: display requester has fixed priority,
// a saturating starvation counter forces the aux requester through periodically.
module disp_vramarb_sel
  import disp_pkg::*;
#(
  parameter int unsigned MAXWAIT = MAXWAIT_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic          ACLK,
  input  logic          ARST,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          arb_i,
  output logic          winner_o,
  output logic [CW-1:0] wait_cnt_o
);

  localparam logic [CW-1:0] MAXWAIT_C = CW'(MAXWAIT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_d;

  // Aux wins a contested arbitration only once the display has won MAXWAIT in a row
  always_comb begin
    winner_o = REQ_DISP;
    if (req0_i && req1_i) begin
      winner_o = (wait_cnt_q == MAXWAIT_C) ? REQ_AUX : REQ_DISP;
    end else if (req1_i) begin
      winner_o = REQ_AUX;
    end else begin
      winner_o = REQ_DISP;
    end
  end

  // Count display grants made while aux was waiting; any aux grant clears it
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (arb_i) begin
      if (winner_o == REQ_AUX) begin
        wait_cnt_d = {CW{1'b0}};
      end else if (req1_i && (wait_cnt_q != MAXWAIT_C)) begin
        wait_cnt_d = wait_cnt_q + ONE_C;
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      wait_cnt_q <= {CW{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_cnt_o = wait_cnt_q;

endmodule

// File: rtl/disp_vramarb.sv
// Two-requester arbiter for the single VRAM AXI read port. One burst in flight;
// the grant is held from AR acceptance to RLAST and R is routed to the owner.
module disp_vramarb
  import disp_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned MAXWAIT = MAXWAIT_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic          ACLK,
  input  logic          ARST,
  input  logic [31:0]   M0_ARADDR,
  input  logic          M0_ARVALID,
  output logic          M0_ARREADY,
  output logic [DW-1:0] M0_RDATA,
  output logic          M0_RLAST,
  output logic          M0_RVALID,
  input  logic          M0_RREADY,
  input  logic [31:0]   M1_ARADDR,
  input  logic          M1_ARVALID,
  output logic          M1_ARREADY,
  output logic [DW-1:0] M1_RDATA,
  output logic          M1_RLAST,
  output logic          M1_RVALID,
  input  logic          M1_RREADY,
  output logic [31:0]   S_ARADDR,
  output logic          S_ARVALID,
  input  logic          S_ARREADY,
  input  logic [DW-1:0] S_RDATA,
  input  logic          S_RLAST,
  input  logic          S_RVALID,
  output logic          S_RREADY,
  output logic          GRANT,
  output logic          BUSY
);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic          grant_q;
  logic          grant_d;
  logic          any_req;
  logic          arbitrate;
  logic          winner;
  logic [CW-1:0] wait_cnt_unused;

  assign any_req   = M0_ARVALID | M1_ARVALID;
  assign arbitrate = (state_q == S_ARB_IDLE) & any_req;

  disp_vramarb_sel #(
    .MAXWAIT (MAXWAIT),
    .CW      (CW)
  ) u_sel (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .req0_i     (M0_ARVALID),
    .req1_i     (M1_ARVALID),
    .arb_i      (arbitrate),
    .winner_o   (winner),
    .wait_cnt_o (wait_cnt_unused)
  );

  assign grant_d = arbitrate ? winner : grant_q;

  // State and owner registers
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q <= S_ARB_IDLE;
      grant_q <= REQ_DISP;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next state: S_ARVALID is held in ADDR even if the owner drops its request
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARB_IDLE: begin
        if (any_req) state_d = S_ARB_ADDR;
        else         state_d = S_ARB_IDLE;
      end
      S_ARB_ADDR: begin
        if (S_ARREADY) state_d = S_ARB_DATA;
        else           state_d = S_ARB_ADDR;
      end
      S_ARB_DATA: begin
        if (S_RVALID && S_RREADY && S_RLAST) state_d = S_ARB_IDLE;
        else                                 state_d = S_ARB_DATA;
      end
      default: state_d = S_ARB_IDLE;
    endcase
  end

  // Output routing; beats arriving outside DATA are never accepted
  always_comb begin
    S_ARVALID  = 1'b0;
    S_ARADDR   = 32'h0000_0000;
    S_RREADY   = 1'b0;
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    M0_RVALID  = 1'b0;
    M1_RVALID  = 1'b0;
    M0_RLAST   = 1'b0;
    M1_RLAST   = 1'b0;
    M0_RDATA   = {DW{1'b0}};
    M1_RDATA   = {DW{1'b0}};
    case (state_q)
      S_ARB_ADDR: begin
        S_ARVALID = 1'b1;
        if (grant_q == REQ_AUX) begin
          S_ARADDR   = M1_ARADDR;
          M1_ARREADY = S_ARREADY;
        end else begin
          S_ARADDR   = M0_ARADDR;
          M0_ARREADY = S_ARREADY;
        end
      end
      S_ARB_DATA: begin
        if (grant_q == REQ_AUX) begin
          M1_RVALID = S_RVALID;
          M1_RLAST  = S_RLAST;
          M1_RDATA  = S_RDATA;
          S_RREADY  = M1_RREADY;
        end else begin
          M0_RVALID = S_RVALID;
          M0_RLAST  = S_RLAST;
          M0_RDATA  = S_RDATA;
          S_RREADY  = M0_RREADY;
        end
      end
      default: begin
        S_ARVALID = 1'b0;
      end
    endcase
  end

  assign GRANT = grant_q;
  assign BUSY  = (state_q != S_ARB_IDLE);

endmodule

// File: doc/disp_vramarb.md
Name: disp_vramarb

Overview:
- Two-requester arbiter for the single AXI read port toward VRAM.
- Requester 0 is the display VRAM reader. It has fixed priority, because the display FIFO must not underrun.
- Requester 1 is a secondary reader (draw/blit engine or capture readback). A starvation counter guarantees it forward progress.
- Supports one outstanding burst at a time. The grant is held from AR acceptance until the RLAST beat, and the R channel is routed back to the granted requester.

Parameters:
- DW, 32: read data width in bits.
- MAXWAIT, 4: number of consecutive requester-0 grants made while requester 1 is waiting, after which requester 1 is forced to win the next arbitration.
- CW, 3: width of the starvation counter. Must satisfy 2^CW > MAXWAIT.

Ports:
- ACLK  in  1  clock
- ARST  in  1  reset, synchronous, active-high
- M0_ARADDR  in  32  requester 0 read address
- M0_ARVALID  in  1  requester 0 address valid
- M0_ARREADY  out  1  address accepted for requester 0
- M0_RDATA  out  DW  read data to requester 0
- M0_RLAST  out  1  last beat to requester 0
- M0_RVALID  out  1  data valid to requester 0
- M0_RREADY  in  1  requester 0 ready for data
- M1_ARADDR, M1_ARVALID, M1_ARREADY, M1_RDATA, M1_RLAST, M1_RVALID, M1_RREADY: same as the M0_* ports, for requester 1
- S_ARADDR  out  32  address to VRAM/interconnect
- S_ARVALID  out  1  address valid to VRAM
- S_ARREADY  in  1  VRAM accepts the address
- S_RDATA  in  DW  read data from VRAM
- S_RLAST  in  1  last beat from VRAM
- S_RVALID  in  1  data valid from VRAM
- S_RREADY  out  1  ready toward VRAM
- GRANT  out  1  current or last owner (0 = M0, 1 = M1); debug/status
- BUSY  out  1  high whenever the state is not IDLE

Behaviour:
- Reset:
  - State goes to IDLE; GRANT=0; wait_cnt=0.
  - All ARREADY, RVALID, RLAST, S_ARVALID and S_RREADY outputs are 0.
  - S_ARADDR is 0. Data outputs are don't-care but are driven as 0.
- State machine, one-hot, three states:
  - IDLE: when M0_ARVALID or M1_ARVALID is high, register the winner into GRANT and go to ADDR. Arbitration therefore costs 1 cycle. With no request, stay in IDLE.
  - ADDR: S_ARVALID=1 and S_ARADDR = the granted requester's ARADDR. The granted requester's ARREADY = S_ARREADY, combinationally. The other requester's ARREADY=0. When S_ARVALID and S_ARREADY are both high, go to DATA.
  - DATA: forward the R channel to the granted requester only: RVALID/RLAST/RDATA from S_*, and S_RREADY = the granted requester's RREADY. The other requester sees RVALID=0. When S_RVALID, S_RREADY and S_RLAST are all high, go to IDLE. A new arbitration can therefore start at the earliest 1 cycle after the last beat.
- Winner selection in IDLE:
  - Only one requester asserting: that requester wins.
  - Both asserting: M0 wins, unless wait_cnt==MAXWAIT, in which case M1 wins.
- wait_cnt:
  - Increments (saturating at MAXWAIT) on each M0 grant issued while M1_ARVALID is high.
  - Clears to 0 on every M1 grant.
  - Otherwise holds.
- Requesters must hold ARVALID and ARADDR stable until ARREADY. If the granted ARVALID drops in ADDR, the arbiter stays in ADDR and keeps S_ARVALID high (AXI stability rule). This is a requester bug and is flagged by assertion in verification.
- Beats outside DATA (S_RVALID high in IDLE or ADDR) are not accepted: S_RREADY=0.
- Reset mid-burst: synchronous reset forces IDLE next edge regardless of state. The outstanding burst is abandoned. Downstream is reset in the same domain.
- Latency:
  - Request to S_ARVALID: 1 cycle.
  - AR path in ADDR and R path in DATA: combinational, 0 cycles.

Decomposition:
- Shared package disp_pkg:
  - state encodings S_ARB_IDLE, S_ARB_ADDR, S_ARB_DATA (one-hot, 3 bits);
  - requester index constants REQ_DISP=0, REQ_AUX=1;
  - default MAXWAIT.
- One natural sub-module: disp_vramarb_sel. It holds the winner selection and the starvation counter. Inputs are the two requests, an arbitrate strobe (IDLE and any request) and ARST. Outputs are the winner index and wait_cnt.
- Muxing and the FSM stay in the top.

Test Plan:
- Only M0 requests address 0x1000_0000 with an 8-beat burst; S_ARREADY delayed 3 cycles:
  - S_ARVALID rises 1 cycle after M0_ARVALID with S_ARADDR=0x1000_0000;
  - M0 receives all 8 beats and M1_RVALID stays 0 throughout;
  - the state returns to IDLE the cycle after RLAST.
- M0 and M1 request continuously with MAXWAIT=4:
  - grant sequence is M0,M0,M0,M0,M1,M0,M0,M0,M0,M1;
  - wait_cnt reaches 4 then clears.
- M0 RREADY toggles 1-0-1 during an 8-beat burst:
  - S_RREADY mirrors it each cycle;
  - no beat is lost or duplicated (compare with an 8-word scoreboard).
- M1 granted and in DATA; M0 asserts ARVALID mid-burst:
  - M0_ARREADY stays 0 until M1's RLAST;
  - M0 is granted next;
  - M1 beats are unaffected.
- ARST asserted in DATA on beat 3 of 8:
  - next cycle all outputs are 0, BUSY=0 and wait_cnt=0;
  - a fresh M0 request afterwards is served normally.
- S_RVALID pulsed while IDLE: S_RREADY=0 and both requester RVALIDs stay 0.
